// File: rtl/rob_if.sv
// rob_if: dispatch / writeback / commit bundle for the reorder buffer.
//   alloc_*  : in-order allocation handshake from dispatch (tag returned)
//   alu_*    : ALU writeback port (target = TAG_INVALID means idle)
//   fwd_*    : forwarder writeback port (same encoding as ALU)
//   commit_* : in-order retirement handshake toward the register file
//   flush    : discard every outstanding entry
//   count    : occupied entries
// master = the surrounding pipeline, slave = the reorder buffer.
interface rob_if #(
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  alu_target;
    logic [DATA_W-1:0] alu_result;
    logic [TAG_W-1:0]  fwd_target;
    logic [DATA_W-1:0] fwd_result;
    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_data;
    logic              commit_ready;
    logic              flush;
    logic [IDX_W:0]    count;

    modport master (
        output alloc_valid, alloc_dest,
        input  alloc_ready, alloc_tag,
        output alu_target, alu_result, fwd_target, fwd_result,
        input  commit_valid, commit_tag, commit_dest, commit_data,
        output commit_ready, flush,
        input  count
    );

    modport slave (
        input  alloc_valid, alloc_dest,
        output alloc_ready, alloc_tag,
        input  alu_target, alu_result, fwd_target, fwd_result,
        output commit_valid, commit_tag, commit_dest, commit_data,
        input  commit_ready, flush,
        output count
    );
endinterface

// File: rtl/rob.sv
// rob: reorder buffer. Allocates entries in program order, captures results
// out of order by tag from two writeback ports (ALU has priority over the
// forwarder on a same-tag collision) and retires done entries in order.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rob_if.slave (alloc, writeback, commit, flush, count)
module rob #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic clk,
    input  logic rst,
    rob_if.slave bus
);
    localparam int             NUM_WB   = 2;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DEPTH-1:0]             done_q, done_d;
    logic [DEPTH-1:0][REG_W-1:0]  dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]             head_q, head_d;
    logic [IDX_W-1:0]             tail_q, tail_d;
    logic [IDX_W:0]               count_q, count_d;

    wb_t  wb [NUM_WB];
    logic alloc_fire;
    logic commit_fire;

    // Port 0 = ALU, port 1 = forwarder; lower index wins a collision.
    always_comb begin
        wb[0] = '{tag: bus.alu_target, data: bus.alu_result};
        wb[1] = '{tag: bus.fwd_target, data: bus.fwd_result};
    end

    // Ready looks only at the registered count, so a same-cycle commit never
    // frees a slot for that cycle's allocation.
    assign bus.alloc_ready  = (count_q != FULL_CNT);
    assign bus.alloc_tag    = {1'b0, tail_q};
    assign bus.commit_valid = busy_q[head_q] && done_q[head_q];
    assign bus.commit_tag   = {1'b0, head_q};
    assign bus.commit_dest  = dest_q[head_q];
    assign bus.commit_data  = data_q[head_q];
    assign bus.count        = count_q;

    assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
    assign commit_fire = bus.commit_valid && bus.commit_ready;

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        dest_d  = dest_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Walk ports lowest-priority first so the ALU overwrites last.
            // Gating on busy_q drops writebacks to an entry allocated this
            // same cycle.
            for (int p = NUM_WB-1; p >= 0; p--) begin
                if (!wb[p].tag[TAG_W-1] && busy_q[wb[p].tag[IDX_W-1:0]]) begin
                    done_d[wb[p].tag[IDX_W-1:0]] = 1'b1;
                    data_d[wb[p].tag[IDX_W-1:0]] = wb[p].data;
                end
            end
            if (commit_fire) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            // Alloc cannot target head while commit fires: that needs the
            // buffer both empty and non-empty.
            if (alloc_fire) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                dest_d[tail_q] = bus.alloc_dest;
                tail_d         = tail_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload only matters while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_rob.sv
module tb_rob;
    localparam logic [3:0] INV = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_if #(.IDX_W(3), .TAG_W(4), .DATA_W(32), .REG_W(5)) bus ();

    rob #(.DEPTH(8), .IDX_W(3), .TAG_W(4), .DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst, fl, av;
        logic [4:0]  ad;
        logic [3:0]  at;
        logic [31:0] ar;
        logic [3:0]  ft;
        logic [31:0] fr;
        logic        cr;
        logic        e_ar;
        logic [3:0]  e_tag;
        logic        e_cv;
        logic [3:0]  e_ct;
        logic [4:0]  e_cd;
        logic [31:0] e_data;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic fl, logic av, logic [4:0] ad,
                                logic [3:0] at, logic [31:0] ar,
                                logic [3:0] ft, logic [31:0] fr, logic cr,
                                logic e_ar, logic [3:0] e_tag, logic e_cv,
                                logic [3:0] e_ct, logic [4:0] e_cd,
                                logic [31:0] e_data, logic [3:0] e_cnt);
        vec_t v;
        v.rst = r; v.fl = fl; v.av = av; v.ad = ad; v.at = at; v.ar = ar;
        v.ft = ft; v.fr = fr; v.cr = cr; v.e_ar = e_ar; v.e_tag = e_tag;
        v.e_cv = e_cv; v.e_ct = e_ct; v.e_cd = e_cd; v.e_data = e_data;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic fl, input logic av,
                          input logic [4:0] ad, input logic [3:0] at,
                          input logic [31:0] ar, input logic [3:0] ft,
                          input logic [31:0] fr, input logic cr);
        @(negedge clk);
        rst              = r;
        bus.flush        = fl;
        bus.alloc_valid  = av;
        bus.alloc_dest   = ad;
        bus.alu_target   = at;
        bus.alu_result   = ar;
        bus.fwd_target   = ft;
        bus.fwd_result   = fr;
        bus.commit_ready = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic cr);
        set_in(0, 0, 0, 0, INV, 0, INV, 0, cr);
        tick();
    endtask

    task automatic alloc(input logic [4:0] d);
        set_in(0, 0, 1, d, INV, 0, INV, 0, 0);
        tick();
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, INV, 0, INV, 0, 0);
        tick();
    endtask

    initial begin
        bus.alloc_valid = 0; bus.alloc_dest = 0; bus.alu_target = INV;
        bus.alu_result = 0; bus.fwd_target = INV; bus.fwd_result = 0;
        bus.commit_ready = 0; bus.flush = 0;

        //               rst fl av ad   at   ar      ft   fr      cr | ar tag cv ct cd  data    cnt
        vecs.push_back(mk(1, 0, 0, 0,  INV, 0,      INV, 0,      0,  1, 0,  0, 0, 0,  0,      0));
        vecs.push_back(mk(0, 0, 0, 0,  2,   32'h55, INV, 0,      0,  1, 0,  0, 0, 0,  0,      0));
        // out-of-order completion
        vecs.push_back(mk(0, 0, 1, 5,  INV, 0,      INV, 0,      1,  1, 1,  0, 0, 0,  0,      1));
        vecs.push_back(mk(0, 0, 1, 6,  INV, 0,      INV, 0,      1,  1, 2,  0, 0, 0,  0,      2));
        vecs.push_back(mk(0, 0, 1, 7,  INV, 0,      INV, 0,      1,  1, 3,  0, 0, 0,  0,      3));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      2,   32'hC,  1,  1, 3,  0, 0, 0,  0,      3));
        vecs.push_back(mk(0, 0, 0, 0,  1,   32'hB,  INV, 0,      1,  1, 3,  0, 0, 0,  0,      3));
        vecs.push_back(mk(0, 0, 0, 0,  0,   32'hA,  INV, 0,      1,  1, 3,  1, 0, 5,  32'hA,  3));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 3,  1, 1, 6,  32'hB,  2));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 3,  1, 2, 7,  32'hC,  1));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 3,  0, 0, 0,  0,      0));
        // same-tag conflict on tag 3
        vecs.push_back(mk(0, 0, 1, 9,  INV, 0,      INV, 0,      0,  1, 4,  0, 0, 0,  0,      1));
        vecs.push_back(mk(0, 0, 0, 0,  3,   32'h11, 3,   32'h22, 0,  1, 4,  1, 3, 9,  32'h11, 1));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 4,  0, 0, 0,  0,      0));
        // alloc/writeback race on tag 4
        vecs.push_back(mk(0, 0, 1, 10, INV, 0,      4,   32'h33, 0,  1, 5,  0, 0, 0,  0,      1));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 5,  0, 0, 0,  0,      1));
        vecs.push_back(mk(0, 0, 0, 0,  4,   32'h44, INV, 0,      1,  1, 5,  1, 4, 10, 32'h44, 1));
        vecs.push_back(mk(0, 0, 0, 0,  INV, 0,      INV, 0,      1,  1, 5,  0, 0, 0,  0,      0));

        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].fl, vecs[i].av, vecs[i].ad, vecs[i].at,
                   vecs[i].ar, vecs[i].ft, vecs[i].fr, vecs[i].cr);
            tick();
            chk($sformatf("v%0d alloc_ready", i), 32'(bus.alloc_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d alloc_tag", i), 32'(bus.alloc_tag), 32'(vecs[i].e_tag));
            chk($sformatf("v%0d commit_valid", i), 32'(bus.commit_valid), 32'(vecs[i].e_cv));
            chk($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].e_cnt));
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d commit_tag", i), 32'(bus.commit_tag), 32'(vecs[i].e_ct));
                chk($sformatf("v%0d commit_dest", i), 32'(bus.commit_dest), 32'(vecs[i].e_cd));
                chk($sformatf("v%0d commit_data", i), bus.commit_data, vecs[i].e_data);
            end
        end

        // Full buffer, then commit and alloc in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(5'(i));
            chk($sformatf("fill%0d count", i), 32'(bus.count), 32'(i + 1));
        end
        chk("full alloc_ready", 32'(bus.alloc_ready), 0);
        set_in(0, 0, 1, 31, 0, 32'h99, INV, 0, 0);
        tick();
        chk("full ignored alloc count", 32'(bus.count), 8);
        chk("full commit_valid", 32'(bus.commit_valid), 1);
        chk("full commit_data", bus.commit_data, 32'h99);
        set_in(0, 0, 1, 20, INV, 0, INV, 0, 1);
        #1;
        chk("full pre-edge alloc_ready", 32'(bus.alloc_ready), 0);
        tick();
        chk("full commit count", 32'(bus.count), 7);
        chk("full wrap alloc_ready", 32'(bus.alloc_ready), 1);
        chk("full wrap alloc_tag", 32'(bus.alloc_tag), 0);
        chk("full next commit_valid", 32'(bus.commit_valid), 0);
        alloc(21);
        chk("refill count", 32'(bus.count), 8);
        chk("refill alloc_tag", 32'(bus.alloc_tag), 1);
        chk("refill alloc_ready", 32'(bus.alloc_ready), 0);

        // Reset with entries outstanding, then flush priority.
        do_reset();
        chk("midreset count", 32'(bus.count), 0);
        chk("midreset commit_valid", 32'(bus.commit_valid), 0);
        for (int i = 0; i < 4; i++) alloc(5'(i + 1));
        set_in(0, 0, 0, 0, 1, 32'h77, INV, 0, 0);
        tick();
        chk("pre-flush count", 32'(bus.count), 4);
        set_in(0, 1, 1, 9, 2, 32'h88, INV, 0, 1);
        tick();
        chk("flush count", 32'(bus.count), 0);
        chk("flush alloc_tag", 32'(bus.alloc_tag), 0);
        chk("flush commit_valid", 32'(bus.commit_valid), 0);
        idle(1);
        chk("post-flush count", 32'(bus.count), 0);
        alloc(1); alloc(2); alloc(3);
        set_in(0, 0, 0, 0, 0, 32'h5, 2, 32'h6, 0);
        tick();
        chk("post-flush commit_valid", 32'(bus.commit_valid), 1);
        chk("post-flush commit_dest", 32'(bus.commit_dest), 1);
        idle(1);
        chk("flushed done cleared", 32'(bus.commit_valid), 0);
        chk("post-flush commit count", 32'(bus.count), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: the receiving end of the execute-to-writeback result path.
- Accepts in-order allocations from dispatch and captures out-of-order results arriving by tag on two writeback ports (ALU and forwarder).
- Retires completed entries strictly in program order toward the architectural register file.
- Tags handed out at allocation are the same tags that come back on the writeback target fields.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- IDX_W, 3, log2(DEPTH); entry index width.
- TAG_W, 4, IDX_W+1; tag width. MSB=1 means TAG_INVALID (all ones); valid tags are 0..DEPTH-1.
- DATA_W, 32, result width.
- REG_W, 5, architectural destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatch requests one entry.
- alloc_dest  in  REG_W  destination register of the allocated instruction.
- alloc_ready  out  1  entry available; high when count<DEPTH.
- alloc_tag  out  TAG_W  tag assigned on the allocation handshake; equals {1'b0,tail}.
- alu_target  in  TAG_W  ALU writeback tag; TAG_INVALID means no writeback.
- alu_result  in  DATA_W  ALU writeback data.
- fwd_target  in  TAG_W  forwarder writeback tag; TAG_INVALID means no writeback.
- fwd_result  in  DATA_W  forwarder writeback data.
- commit_valid  out  1  head entry is busy and done.
- commit_tag  out  TAG_W  tag of the head entry.
- commit_dest  out  REG_W  destination of the head entry.
- commit_data  out  DATA_W  result of the head entry.
- commit_ready  in  1  consumer accepts the commit.
- flush  in  1  discard all entries.
- count  out  IDX_W+1  number of occupied entries.

Behaviour:
- Storage: per entry busy, done, dest, data. Also head and tail (IDX_W bits, wrap modulo DEPTH) and count.
- Reset (rst high at posedge):
  - all busy and done cleared; head=tail=count=0.
  - After reset: alloc_ready=1, alloc_tag=0, commit_valid=0, count=0.
  - dest and data are not reset.
- Allocate: on alloc_valid && alloc_ready, entry[tail] gets busy=1, done=0, dest=alloc_dest; tail++.
  - alloc_ready is derived from registered count only. A commit in the same cycle does not free a slot for that cycle's allocation.
  - alloc_valid while not ready is ignored.
- Writeback, per port: if target MSB=0 and entry[target[IDX_W-1:0]].busy, then done=1 and data=result.
  - Writeback to a non-busy entry is dropped.
  - This includes an entry being allocated in the same cycle, since busy is still 0 before the edge.
- Both ports with the same valid tag in one cycle: ALU data wins; the forwarder data is dropped.
- Commit outputs are combinational from registered state:
  - commit_valid = busy[head] && done[head].
  - commit_tag = {1'b0,head}.
  - commit_dest and commit_data come from entry[head].
- On commit_valid && commit_ready: busy[head]=0, done[head]=0, head++.
- Writeback-to-commit latency: a result written at edge N can commit in the cycle after edge N, never combinationally in the same cycle.
- count update: count + (alloc fire) - (commit fire). Simultaneous alloc and commit leaves count unchanged.
- Full (count=DEPTH): alloc_ready=0; writeback and commit continue normally.
- Empty (count=0): commit_valid=0.
- Wrap-around: head and tail roll from DEPTH-1 to 0 with no bubble.
- flush (sync): same effect as reset on busy, done, head, tail and count.
  - Takes priority over alloc, writeback and commit in the same cycle; none of those take effect.
- Reset mid-operation: identical to flush; no outstanding entry survives.

Test Plan:
- Reset check: pulse rst → alloc_ready=1, alloc_tag=0, count=0, commit_valid=0. A writeback with alu_target=2 in the next cycle is dropped, and count stays 0.
- Out-of-order completion:
  - Stimulus: alloc dests 5,6,7 (tags 0,1,2); then fwd_target=2 data 0xC; then alu_target=1 data 0xB; then alu_target=0 data 0xA; commit_ready held 1.
  - Response: no commit until tag 0 is written. Then commits on consecutive cycles: (tag0,dest5,0xA), (tag1,dest6,0xB), (tag2,dest7,0xC). count ends at 0.
- Full plus simultaneous alloc/commit:
  - Stimulus: fill 8 entries with commit_ready=0; write back tag 0; assert commit_ready and alloc_valid together.
  - Response: with count=8, alloc_ready=0 and no allocation in the commit cycle; count goes 8→7. Next cycle alloc_ready=1 and alloc_tag=0 (wrapped); that allocation fires and count returns to 8.
- Same-tag conflict: alloc tag 3; alu_target=3 data 0x11 and fwd_target=3 data 0x22 in the same cycle → commit_data=0x11 at commit.
- Flush priority:
  - Stimulus: 4 entries outstanding, tag 1 done; assert flush together with alloc_valid, alu_target=2 and commit_ready=1.
  - Response: next cycle count=0, alloc_tag=0, commit_valid=0; no commit and no allocation occurred.
- Alloc/writeback race: the same cycle tag 4 is allocated, fwd_target=4 is presented → entry stays done=0. A writeback of tag 4 one cycle later marks it done.
